// File: rtl/bayer_pkg.sv
// Shared types for the Bayer 2x2 window stream: frame FSM states and the
// reordered {R, Gr, Gb, B} quad at the default pixel width.
package bayer_pkg;

  localparam int DEFAULT_PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEFAULT_PIX_W-1:0] r;
    logic [DEFAULT_PIX_W-1:0] gr;
    logic [DEFAULT_PIX_W-1:0] gb;
    logic [DEFAULT_PIX_W-1:0] b;
  } quad_t;

endpackage

// File: rtl/bayer_line_buffer.sv
// One-row pixel store: synchronous write, combinational read, no storage reset.
// Reading and writing the same address in one cycle returns the old pixel.
// No flow control; the caller qualifies the write enable.
module bayer_line_buffer #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bayer_window_stream.sv
// Raster RGGB pixels in, registered 2x2 window reordered to {R, Gr, Gb, B} out.
// Latency: 1 cycle from the accepting handshake to out_valid.
// Backpressure: in_ready = !out_valid || out_ready while running; border windows need BAYER_BORDER_REPLICATE_EN.
module bayer_window_stream
  import bayer_pkg::*;
#(
  parameter int PIX_W     = DEFAULT_PIX_W,
  parameter int DIM_W     = 13,
  parameter int MAX_WIDTH = 4096
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   img_width,
  input  logic [DIM_W-1:0]   img_height,
  input  logic               in_valid,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*PIX_W-1:0] out_quad,
  output logic [DIM_W-1:0]   out_row,
  output logic [DIM_W-1:0]   out_col,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int AW = $clog2(MAX_WIDTH);
  localparam logic [DIM_W:0] MAX_W_L = (DIM_W+1)'(MAX_WIDTH);

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] gr;
    logic [PIX_W-1:0] gb;
    logic [PIX_W-1:0] b;
  } win_t;

  state_t           state;
  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;
  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;
  logic [PIX_W-1:0] ul;
  logic [PIX_W-1:0] left;
  logic [PIX_W-1:0] upper;

  logic             accept;
  logic             emit;
  logic             cfg_ok;
  logic             at_last_col;
  logic             at_last_row;
  logic [PIX_W-1:0] tl, tr, bl, br;
  win_t             quad_nx;
  win_t             quad_q;

  assign in_ready    = (state == RUN) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign at_last_col = (col == w_q - DIM_W'(1));
  assign at_last_row = (row == h_q - DIM_W'(1));
  assign busy        = (state != IDLE);
  assign out_quad    = quad_q;

  assign cfg_ok = (img_width >= DIM_W'(2)) && ({1'b0, img_width} <= MAX_W_L) &&
                  (img_height >= DIM_W'(2));

  bayer_line_buffer #(
    .PIX_W (PIX_W),
    .DEPTH (MAX_WIDTH),
    .AW    (AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .addr  (col[AW-1:0]),
    .wdata (in_pix),
    .rdata (upper)
  );

`ifdef BAYER_BORDER_REPLICATE_EN
  // Missing neighbours outside the image are replaced by the nearest real tap.
  logic [PIX_W-1:0] up_eff;
  logic [PIX_W-1:0] ul_eff;

  always_comb begin
    up_eff = (row == '0) ? in_pix : upper;
    ul_eff = (row == '0) ? left : ul;
    tr     = up_eff;
    br     = in_pix;
    tl     = (col == '0) ? up_eff : ul_eff;
    bl     = (col == '0) ? in_pix : left;
  end

  assign emit = accept;
`else
  always_comb begin
    tl = ul;
    tr = upper;
    bl = left;
    br = in_pix;
  end

  assign emit = accept && (row != '0) && (col != '0);
`endif

  // The bottom-right pixel's coordinate parity decides where R sits in the window.
  always_comb begin
    quad_nx = '0;
    case ({row[0], col[0]})
      2'b11: begin
        quad_nx.r = tl; quad_nx.gr = tr; quad_nx.gb = bl; quad_nx.b = br;
      end
      2'b10: begin
        quad_nx.r = tr; quad_nx.gr = tl; quad_nx.gb = br; quad_nx.b = bl;
      end
      2'b01: begin
        quad_nx.r = bl; quad_nx.gr = br; quad_nx.gb = tl; quad_nx.b = tr;
      end
      default: begin
        quad_nx.r = br; quad_nx.gr = bl; quad_nx.gb = tr; quad_nx.b = tl;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col     <= '0;
      row     <= '0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              w_q   <= img_width;
              h_q   <= img_height;
              col   <= '0;
              row   <= '0;
              state <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            if (at_last_col) begin
              col <= '0;
              row <= row + DIM_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
            if (at_last_col && at_last_row) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!out_valid) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ul        <= '0;
      left      <= '0;
      out_valid <= 1'b0;
      quad_q    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        ul   <= upper;
        left <= in_pix;
      end
      // emit implies in_ready, so an unconsumed window is never overwritten.
      if (emit) begin
        out_valid <= 1'b1;
        quad_q    <= quad_nx;
        out_row   <= row;
        out_col   <= col;
        out_last  <= at_last_col && at_last_row;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bayer_window_stream.sv
// Bench for bayer_window_stream: directed and random frames against a
// coordinate-level 2x2 window model.
module tb_bayer_window_stream;
  import bayer_pkg::*;

  localparam int PW = 8;
  localparam int DW = 13;
  localparam int MW = 4096;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            start;
  logic [DW-1:0]   img_width;
  logic [DW-1:0]   img_height;
  logic            in_valid;
  logic [PW-1:0]   in_pix;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [4*PW-1:0] out_quad;
  logic [DW-1:0]   out_row;
  logic [DW-1:0]   out_col;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            cfg_err;

  bayer_window_stream #(.PIX_W(PW), .DIM_W(DW), .MAX_WIDTH(MW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .in_valid   (in_valid),
    .in_pix     (in_pix),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_quad   (out_quad),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int           pix[$];
  logic [58:0]  exp_q[$];
  bit           emits[$];
  logic [58:0]  got[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [58:0] win(int r, int gr, int gb, int b, int row, int col, bit last);
    return {8'(r), 8'(gr), 8'(gb), 8'(b), 13'(row), 13'(col), last};
  endfunction

  // Each tap keeps its virtual image position; its colour is that position's
  // RGGB site, its value the nearest in-image pixel (clamping only matters at borders).
  task automatic build_expected(input int w, input int h);
    exp_q.delete();
    emits.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        bit    em;
        quad_t q;
`ifdef BAYER_BORDER_REPLICATE_EN
        em = 1'b1;
`else
        em = (r > 0) && (c > 0);
`endif
        emits.push_back(em);
        if (em) begin
          q = '0;
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              int vr, vc, val;
              vr  = r - 1 + dr;
              vc  = c - 1 + dc;
              val = pix[(vr < 0 ? 0 : vr) * w + (vc < 0 ? 0 : vc)];
              case ({((vr + 2) % 2) == 1, ((vc + 2) % 2) == 1})
                2'b00:   q.r  = 8'(val);
                2'b01:   q.gr = 8'(val);
                2'b10:   q.gb = 8'(val);
                default: q.b  = 8'(val);
              endcase
            end
          end
          exp_q.push_back({q, 13'(r), 13'(c), (r == h - 1) && (c == w - 1)});
        end
      end
    end
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0, 2 random. restart_at >= 0 pulses
  // start (with different dimensions) when that pixel index is offered.
  task automatic run_frame(input int w, input int h, input int rdy_mode,
                           input bit gap, input int restart_at);
    int          n, n_exp, pi, cyc, done_cnt, budget, er, ec;
    bit          stalled_prev, emit_prev, free_prev, restarted, cfg_seen;
    logic [58:0] held, cur;
    n = w * h;
    build_expected(w, h);
    n_exp = exp_q.size();
    got.delete();
    pi = 0; cyc = 0; done_cnt = 0; budget = 40 * n + 200; er = 0; ec = 0;
    stalled_prev = 0; emit_prev = 0; free_prev = 1; restarted = 0; cfg_seen = 0;
    held = '0;

    @(negedge clk);
    img_width = DW'(w); img_height = DW'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1 check("busy_after_start", 64'(busy), 64'(1));

    while (done_cnt == 0 && cyc < budget) begin
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3) == 0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (pi < n) && (gap ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_pix   = (pi < n) ? 8'(pix[pi]) : 8'($urandom);
      if (!restarted && restart_at >= 0 && pi == restart_at) begin
        start = 1'b1; restarted = 1'b1; img_width = DW'(3); img_height = DW'(2);
      end else begin
        start = 1'b0;
      end
      #1;
      cur = {out_quad, out_row, out_col, out_last};
      if (emit_prev) begin
        check("latency_valid", 64'(out_valid), 64'(1));
        check("latency_coord", 64'({out_row, out_col}), 64'({13'(er), 13'(ec)}));
      end else if (free_prev) begin
        check("valid_fall", 64'(out_valid), 64'(0));
      end
      if (stalled_prev) check("stall_hold", 64'(cur), 64'(held));
      if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_window", 64'(got.size() + 1), 64'(n_exp));
        else check("window", 64'(cur), 64'(exp_q.pop_front()));
        got.push_back(cur);
      end
      if (cfg_err) cfg_seen = 1'b1;
      if (done) begin
        done_cnt++;
        check("done_after_all", 64'(got.size()), 64'(n_exp));
      end
      emit_prev    = in_valid && in_ready && emits[pi];
      er           = pi / w;
      ec           = pi % w;
      free_prev    = out_ready || !out_valid;
      stalled_prev = out_valid && !out_ready;
      held         = cur;
      if (in_valid && in_ready) pi++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
    check("frame_done_seen", 64'(done_cnt), 64'(1));
    check("window_count", 64'(got.size()), 64'(n_exp));
    check("no_cfg_err", 64'(cfg_seen), 64'(0));
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    check("done_pulse_width", 64'(done), 64'(0));
  endtask

  task automatic cfg_try(input int w, input int h, input string tag);
    @(negedge clk);
    img_width = DW'(w); img_height = DW'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_cfg_err"}, 64'(cfg_err), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    @(negedge clk);
    #1 check({tag, "_cfg_err_pulse"}, 64'(cfg_err), 64'(0));
  endtask

  initial begin
    int done_seen;
    n_rst = 1'b0; start = 1'b0; img_width = '0; img_height = '0;
    in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_flags", 64'({done, cfg_err, out_last}), 64'(0));
    check("rst_out_data", 64'({out_quad, out_row, out_col}), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;

    // Mid-frame reset: 6 pixels into a 4x4 frame, with a window pending.
    @(negedge clk);
    img_width = DW'(4); img_height = DW'(4); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_pix = 8'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 check("pre_rst_window", 64'({out_valid, out_row, out_col}), 64'({1'b1, 13'd1, 13'd1}));
    n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 if (done) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'(0));

    // Basic 4x3 frame, raster-index pixels.
    pix.delete();
    for (int k = 0; k < 12; k++) pix.push_back(k);
    run_frame(4, 3, 0, 0, -1);
`ifndef BAYER_BORDER_REPLICATE_EN
    check("basic_count", 64'(got.size()), 64'(6));
    check("basic_first", 64'(got[0]), 64'(win(0, 1, 4, 5, 1, 1, 0)));
    check("basic_second", 64'(got[1]), 64'(win(2, 1, 6, 5, 1, 2, 0)));
    check("basic_last", 64'(got[5]), 64'(win(10, 11, 6, 7, 2, 3, 1)));
`endif

    // Same frame under 1,0,0 backpressure.
    run_frame(4, 3, 1, 0, -1);
`ifndef BAYER_BORDER_REPLICATE_EN
    check("bp_count", 64'(got.size()), 64'(6));
    check("bp_first", 64'(got[0]), 64'(win(0, 1, 4, 5, 1, 1, 0)));
`endif

    cfg_try(1, 4, "width_one");
    cfg_try(MW + 1, 4, "width_over");
    cfg_try(4, 1, "height_one");

`ifdef BAYER_BORDER_REPLICATE_EN
    pix.delete();
    pix.push_back(10); pix.push_back(20); pix.push_back(30); pix.push_back(40);
    run_frame(2, 2, 0, 0, -1);
    check("repl_count", 64'(got.size()), 64'(4));
    check("repl_00", 64'(got[0]), 64'(win(10, 10, 10, 10, 0, 0, 0)));
    check("repl_01", 64'(got[1]), 64'(win(10, 20, 10, 20, 0, 1, 0)));
    check("repl_11", 64'(got[3]), 64'(win(10, 20, 30, 40, 1, 1, 1)));
`endif

    // start while running is ignored.
    pix.delete();
    for (int k = 0; k < 20; k++) pix.push_back(int'($urandom_range(0, 255)));
    run_frame(5, 4, 0, 1, 7);

    // Random frames with gaps and random backpressure.
    for (int f = 0; f < 6; f++) begin
      int w, h;
      w = int'($urandom_range(2, 9));
      h = int'($urandom_range(2, 6));
      pix.delete();
      for (int k = 0; k < w * h; k++) pix.push_back(int'($urandom_range(0, 255)));
      run_frame(w, h, 2, 1, -1);
    end

    // Maximum width exercises every line buffer address.
    pix.delete();
    for (int k = 0; k < 2 * MW; k++) pix.push_back(int'($urandom_range(0, 255)));
    run_frame(MW, 2, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
